// File: rtl/musk_bus_arbiter.sv
// Round-robin arbiter sharing one Sysbus request/response channel between NREQ Muskbus clients.
// A grant is held for a whole transaction; responses route back to the client by ID bits in the tag.
module musk_bus_arbiter #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned IDW   = 1,
  parameter int unsigned BEATS = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            cl_reqcyc,
  input  logic [NREQ-1:0][63:0]      cl_req,
  input  logic [NREQ-1:0][12:0]      cl_reqtag,
  output logic [NREQ-1:0]            cl_reqack,
  output logic [NREQ-1:0]            cl_respcyc,
  output logic [63:0]                cl_resp,
  input  logic [NREQ-1:0]            cl_respack,
  output logic                       bus_reqcyc,
  output logic [63:0]                bus_req,
  output logic [12:0]                bus_reqtag,
  input  logic                       bus_reqack,
  input  logic                       bus_respcyc,
  input  logic [63:0]                bus_resp,
  input  logic [12:0]                bus_resptag,
  output logic                       bus_respack,
  output logic                       tag_err
);

  localparam int unsigned TW  = 13;
  localparam int unsigned GW  = (NREQ > 2) ? 2 : 1;
  localparam int unsigned BCW = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, WDATA} state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   g_q, g_d;
  logic [GW-1:0]   rr_q, rr_d;
  logic [BCW-1:0]  beat_q, beat_d;
  logic            tag_err_q, tag_err_d;

  logic [GW-1:0]   win;
  logic            found;
  logic [GW-1:0]   rr_after_g;
  logic [TW-1:0]   tag_sel;
  logic [IDW-1:0]  resp_id;
  logic            id_ok;
  logic            ack_sel;
  logic            resptag_unused;

  // Round-robin pick: first requester at or above rr_q, else first from index 0.
  always_comb begin
    win   = rr_q;
    found = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (!found && cl_reqcyc[i] && (GW'(i) >= rr_q)) begin
        win   = GW'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < int'(NREQ); i++) begin
      if (!found && cl_reqcyc[i]) begin
        win   = GW'(i);
        found = 1'b1;
      end
    end
  end

  assign rr_after_g = (g_q == GW'(NREQ - 1)) ? '0 : g_q + 1'b1;

  always_comb begin
    tag_sel            = cl_reqtag[g_q];
    tag_sel[IDW-1:0]   = IDW'(g_q);
  end

  assign bus_req    = cl_req[g_q];
  assign bus_reqtag = tag_sel;

  // Request FSM: next state and the combinational request/ack pass-through.
  always_comb begin
    state_d    = state_q;
    g_d        = g_q;
    rr_d       = rr_q;
    beat_d     = beat_q;
    bus_reqcyc = 1'b0;
    cl_reqack  = '0;
    case (state_q)
      IDLE: begin
        if (|cl_reqcyc) begin
          g_d     = win;
          state_d = ADDR;
        end
      end
      ADDR, WDATA: begin
        bus_reqcyc     = cl_reqcyc[g_q];
        cl_reqack[g_q] = bus_reqack;
        if (bus_reqack && bus_reqcyc) begin
          if (state_q == ADDR) begin
            if (tag_sel[12]) begin
              state_d = WDATA;
              beat_d  = '0;
            end else begin
              state_d = IDLE;
              rr_d    = rr_after_g;
            end
          end else if (beat_q == BCW'(BEATS - 1)) begin
            state_d = IDLE;
            rr_d    = rr_after_g;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Response routing by tag ID; out-of-range IDs are swallowed and flagged.
  assign resp_id        = bus_resptag[IDW-1:0];
  assign resptag_unused = ^bus_resptag[TW-1:IDW];

  always_comb begin
    id_ok      = 1'b0;
    ack_sel    = 1'b0;
    cl_respcyc = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (resp_id == IDW'(i)) begin
        id_ok         = 1'b1;
        ack_sel       = cl_respack[i];
        cl_respcyc[i] = bus_respcyc & reset;
      end
    end
  end

  assign bus_respack = reset & (id_ok ? ack_sel : bus_respcyc);
  assign cl_resp     = bus_resp;
  assign tag_err_d   = tag_err_q | (bus_respcyc & ~id_ok);
  assign tag_err     = tag_err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      g_q       <= '0;
      rr_q      <= '0;
      beat_q    <= '0;
      tag_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      rr_q      <= rr_d;
      beat_q    <= beat_d;
      tag_err_q <= tag_err_d;
    end
  end

endmodule
